// File: rtl/rab_cfg_pkg.sv
// Shared definitions for the RAB slice configuration register file:
// register offsets within a slice, flag bit positions, AXI response codes,
// the handshake FSM state type and the per-register writable-field mask.
package rab_cfg_pkg;

    // Position of each register inside a slice's group of four
    localparam logic [1:0] REG_MIN    = 2'd0;
    localparam logic [1:0] REG_MAX    = 2'd1;
    localparam logic [1:0] REG_OFFSET = 2'd2;
    localparam logic [1:0] REG_FLAGS  = 2'd3;

    // Bit positions inside the flags register
    localparam int FLAG_EN      = 0;
    localparam int FLAG_REN     = 1;
    localparam int FLAG_WEN     = 2;
    localparam int FLAG_MST_SEL = 3;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // One transaction in flight at a time: idle, or waiting on B or R
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRESP = 2'd1,
        ST_RRESP = 2'd2
    } state_t;

    // Bits of a register that actually store data; everything else reads 0
    function automatic logic [63:0] field_mask(input logic [1:0] reg_off,
                                               input int virt_w,
                                               input int phys_w);
        logic [63:0] mask;
        mask = '0;
        case (reg_off)
            REG_MIN, REG_MAX: mask = (64'd1 << virt_w) - 64'd1;
            REG_OFFSET:       mask = (64'd1 << phys_w) - 64'd1;
            default: begin
                mask[FLAG_EN]      = 1'b1;
                mask[FLAG_REN]     = 1'b1;
                mask[FLAG_WEN]     = 1'b1;
                mask[FLAG_MST_SEL] = 1'b1;
            end
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/rab_cfg_regfile.sv
// AXI4-Lite slave holding the RAB slice configuration registers (min, max,
// offset, flags per slice). AW and W are captured independently into
// holding registers; a complete pair is committed before any read is taken.
module rab_cfg_regfile
    import rab_cfg_pkg::*;
#(
    parameter int N_SLICES        = 16,
    parameter int N_REGS          = 4 * N_SLICES,
    parameter int ADDR_WIDTH_PHYS = 40,
    parameter int ADDR_WIDTH_VIRT = 32,
    parameter int AXI_ADDR_WIDTH  = 32
) (
    input  logic                            Clk_CI,
    input  logic                            Rst_RI,
    input  logic [AXI_ADDR_WIDTH-1:0]       s_awaddr,
    input  logic                            s_awvalid,
    output logic                            s_awready,
    input  logic [63:0]                     s_wdata,
    input  logic [7:0]                      s_wstrb,
    input  logic                            s_wvalid,
    output logic                            s_wready,
    output logic [1:0]                      s_bresp,
    output logic                            s_bvalid,
    input  logic                            s_bready,
    input  logic [AXI_ADDR_WIDTH-1:0]       s_araddr,
    input  logic                            s_arvalid,
    output logic                            s_arready,
    output logic [63:0]                     s_rdata,
    output logic [1:0]                      s_rresp,
    output logic                            s_rvalid,
    input  logic                            s_rready,
    output logic [N_REGS-1:0][63:0]         int_cfg_regs,
    output logic [N_SLICES-1:0]             cfg_upd
);

    localparam int IDX_W = AXI_ADDR_WIDTH - 3;
    localparam int SEL_W = $clog2(N_REGS);
    localparam logic [IDX_W-1:0] N_REGS_IDX = IDX_W'(N_REGS);

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        aw_q;
    logic                    aw_held;
    logic [63:0]             w_q;
    logic [7:0]              w_strb_q;
    logic                    w_held;

    logic                    aw_fire, w_fire, commit, rd_accept;
    logic                    wr_ok, rd_ok;
    logic [SEL_W-1:0]        wr_sel, rd_sel;
    logic [IDX_W-1:0]        rd_idx;
    logic [63:0]             wr_old, wr_merged, wr_new;

    logic [N_REGS-1:0][63:0] regs_q;
    logic                    bvalid_q, rvalid_q;
    logic [1:0]              bresp_q, rresp_q;
    logic [63:0]             rdata_q;
    logic [N_SLICES-1:0]     cfg_upd_q;
    logic                    unused_addr_bits;

    // Byte offset bits carry no meaning; the register index starts at bit 3
    assign unused_addr_bits = ^{s_awaddr[2:0], s_araddr[2:0]};

    assign s_awready = !aw_held && (state_q == ST_IDLE);
    assign s_wready  = !w_held  && (state_q == ST_IDLE);
    assign s_arready = (state_q == ST_IDLE) && !(aw_held && w_held);

    assign aw_fire = s_awvalid && s_awready;
    assign w_fire  = s_wvalid  && s_wready;

    assign wr_ok  = aw_q < N_REGS_IDX;
    assign wr_sel = aw_q[SEL_W-1:0];
    assign rd_idx = s_araddr[AXI_ADDR_WIDTH-1:3];
    assign rd_ok  = rd_idx < N_REGS_IDX;
    assign rd_sel = s_araddr[3 +: SEL_W];

    assign int_cfg_regs = regs_q;
    assign cfg_upd      = cfg_upd_q;
    assign s_bvalid     = bvalid_q;
    assign s_bresp      = bresp_q;
    assign s_rvalid     = rvalid_q;
    assign s_rresp      = rresp_q;
    assign s_rdata      = rdata_q;

    // Next-state logic: a held write pair wins over a pending read
    always_comb begin
        state_d   = state_q;
        commit    = 1'b0;
        rd_accept = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (aw_held && w_held) begin
                    commit  = 1'b1;
                    state_d = ST_WRESP;
                end else if (s_arvalid) begin
                    rd_accept = 1'b1;
                    state_d   = ST_RRESP;
                end
            end
            ST_WRESP: if (s_bready) state_d = ST_IDLE;
            ST_RRESP: if (s_rready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Merge strobed bytes over the old value, then drop non-storage bits
    always_comb begin
        wr_old    = regs_q[wr_sel];
        wr_merged = wr_old;
        for (int b = 0; b < 8; b++) begin
            if (w_strb_q[b]) wr_merged[b*8 +: 8] = w_q[b*8 +: 8];
        end
        wr_new = wr_merged & field_mask(wr_sel[1:0], ADDR_WIDTH_VIRT, ADDR_WIDTH_PHYS);
    end

    // FSM state register
    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Capture AW and W independently; both holds release on commit
    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            aw_q     <= '0;
            aw_held  <= 1'b0;
            w_q      <= '0;
            w_strb_q <= '0;
            w_held   <= 1'b0;
        end else begin
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
            if (aw_fire) begin
                aw_q    <= s_awaddr[AXI_ADDR_WIDTH-1:3];
                aw_held <= 1'b1;
            end
            if (w_fire) begin
                w_q      <= s_wdata;
                w_strb_q <= s_wstrb;
                w_held   <= 1'b1;
            end
        end
    end

    // Register array update on an in-range commit
    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI)                regs_q <= '0;
        else if (commit && wr_ok)  regs_q[wr_sel] <= wr_new;
    end

    // Write response and per-slice update pulse
    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            cfg_upd_q <= '0;
        end else begin
            cfg_upd_q <= '0;
            if (commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                if (wr_ok) cfg_upd_q[wr_sel[SEL_W-1:2]] <= 1'b1;
            end else if (state_q == ST_WRESP && s_bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // Read response, sampled from the register array at the AR handshake
    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else if (rd_accept) begin
            rvalid_q <= 1'b1;
            rresp_q  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            rdata_q  <= rd_ok ? regs_q[rd_sel] : 64'd0;
        end else if (state_q == ST_RRESP && s_rready) begin
            rvalid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rab_cfg_regfile.sv
// Testbench for rab_cfg_regfile: directed scenarios plus randomized
// traffic, all checked against an array model of the register file.
module tb_rab_cfg_regfile;

    localparam int N_SLICES = 16;
    localparam int N_REGS   = 4 * N_SLICES;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [31:0]              s_awaddr;
    logic                     s_awvalid, s_awready;
    logic [63:0]              s_wdata;
    logic [7:0]               s_wstrb;
    logic                     s_wvalid, s_wready;
    logic [1:0]               s_bresp;
    logic                     s_bvalid, s_bready;
    logic [31:0]              s_araddr;
    logic                     s_arvalid, s_arready;
    logic [63:0]              s_rdata;
    logic [1:0]               s_rresp;
    logic                     s_rvalid, s_rready;
    logic [N_REGS-1:0][63:0]  int_cfg_regs;
    logic [N_SLICES-1:0]      cfg_upd;

    int          tests_run    = 0;
    int          tests_failed = 0;
    int          upd_total    = 0;
    logic [63:0] model_regs [N_REGS];

    rab_cfg_regfile dut (
        .Clk_CI       (clk),
        .Rst_RI       (rst),
        .s_awaddr     (s_awaddr),
        .s_awvalid    (s_awvalid),
        .s_awready    (s_awready),
        .s_wdata      (s_wdata),
        .s_wstrb      (s_wstrb),
        .s_wvalid     (s_wvalid),
        .s_wready     (s_wready),
        .s_bresp      (s_bresp),
        .s_bvalid     (s_bvalid),
        .s_bready     (s_bready),
        .s_araddr     (s_araddr),
        .s_arvalid    (s_arvalid),
        .s_arready    (s_arready),
        .s_rdata      (s_rdata),
        .s_rresp      (s_rresp),
        .s_rvalid     (s_rvalid),
        .s_rready     (s_rready),
        .int_cfg_regs (int_cfg_regs),
        .cfg_upd      (cfg_upd)
    );

    always #5 clk = ~clk;

    // Total number of slice-update pulses seen, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst) upd_total = upd_total + $countones(cfg_upd);
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference write: in range -> strobed bytes, then keep only storage bits
    function automatic logic [1:0] modelWrite(input logic [31:0] addr, input logic [63:0] data,
                                              input logic [7:0] strb);
        int          idx;
        int          off;
        logic [63:0] mask;
        idx = int'(addr >> 3);
        if (idx >= N_REGS) return 2'b10;
        off = idx % 4;
        if (off < 2)       mask = 64'h0000_0000_FFFF_FFFF;
        else if (off == 2) mask = 64'h0000_00FF_FFFF_FFFF;
        else               mask = 64'h0000_0000_0000_000F;
        for (int b = 0; b < 8; b++) begin
            if (strb[b]) model_regs[idx][b*8 +: 8] = data[b*8 +: 8];
        end
        model_regs[idx] = model_regs[idx] & mask;
        return 2'b00;
    endfunction

    function automatic int regMismatches();
        int bad = 0;
        for (int i = 0; i < N_REGS; i++) begin
            if (int_cfg_regs[i] !== model_regs[i]) bad++;
        end
        return bad;
    endfunction

    function automatic void modelReset();
        for (int i = 0; i < N_REGS; i++) model_regs[i] = 64'd0;
    endfunction

    // Full write transaction with independent AW/W delays and a B stall
    task automatic applyStimulus(input string tag, input logic [31:0] addr, input logic [63:0] data,
                                 input logic [7:0] strb, input int aw_dly, input int w_dly,
                                 input int b_stall);
        int                  cyc;
        bit                  aw_done, w_done;
        int                  upd_before;
        logic [1:0]          exp_resp;
        logic [N_SLICES-1:0] exp_upd;
        int                  idx;
        cyc = 0; aw_done = 0; w_done = 0;
        idx = int'(addr >> 3);
        while (!(aw_done && w_done) && cyc < 20) begin
            s_awvalid = !aw_done && (cyc >= aw_dly);
            s_awaddr  = addr;
            s_wvalid  = !w_done && (cyc >= w_dly);
            s_wdata   = data;
            s_wstrb   = strb;
            @(negedge clk);
            if (s_awvalid && s_awready) aw_done = 1;
            if (s_wvalid && s_wready)   w_done  = 1;
            @(posedge clk); #1;
            cyc++;
        end
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        checkOutput({tag, "_handshakes"}, 64'(aw_done && w_done), 64'd1);
        checkOutput({tag, "_bvalid_early"}, 64'(s_bvalid), 64'd0);
        checkOutput({tag, "_regs_before_commit"}, 64'(regMismatches()), 64'd0);
        upd_before = upd_total;
        exp_resp   = modelWrite(addr, data, strb);
        exp_upd    = '0;
        if (exp_resp == 2'b00) exp_upd[idx / 4] = 1'b1;
        @(posedge clk); #1;
        checkOutput({tag, "_bvalid"}, 64'(s_bvalid), 64'd1);
        checkOutput({tag, "_bresp"}, 64'(s_bresp), 64'(exp_resp));
        checkOutput({tag, "_cfg_upd"}, 64'(cfg_upd), 64'(exp_upd));
        checkOutput({tag, "_regs"}, 64'(regMismatches()), 64'd0);
        for (int k = 0; k < b_stall; k++) begin
            @(posedge clk); #1;
            checkOutput({tag, "_bvalid_hold"}, 64'(s_bvalid), 64'd1);
            checkOutput({tag, "_bresp_hold"}, 64'(s_bresp), 64'(exp_resp));
        end
        s_bready = 1'b1;
        @(posedge clk); #1;
        s_bready = 1'b0;
        checkOutput({tag, "_bvalid_clear"}, 64'(s_bvalid), 64'd0);
        checkOutput({tag, "_upd_count"}, 64'(upd_total - upd_before), 64'(exp_resp == 2'b00));
    endtask

    // Full read transaction with an R stall, checked against the model
    task automatic readBack(input string tag, input logic [31:0] addr, input int r_stall);
        int          cyc;
        bit          hs;
        int          idx;
        logic [63:0] exp_data;
        logic [1:0]  exp_resp;
        idx      = int'(addr >> 3);
        exp_data = (idx < N_REGS) ? model_regs[idx] : 64'd0;
        exp_resp = (idx < N_REGS) ? 2'b00 : 2'b10;
        cyc = 0; hs = 0;
        s_arvalid = 1'b1;
        s_araddr  = addr;
        while (!hs && cyc < 20) begin
            @(negedge clk);
            hs = s_arready;
            @(posedge clk); #1;
            cyc++;
        end
        s_arvalid = 1'b0;
        checkOutput({tag, "_ar_handshake"}, 64'(hs), 64'd1);
        checkOutput({tag, "_rvalid"}, 64'(s_rvalid), 64'd1);
        checkOutput({tag, "_rdata"}, s_rdata, exp_data);
        checkOutput({tag, "_rresp"}, 64'(s_rresp), 64'(exp_resp));
        for (int k = 0; k < r_stall; k++) begin
            @(posedge clk); #1;
            checkOutput({tag, "_rvalid_hold"}, 64'(s_rvalid), 64'd1);
            checkOutput({tag, "_rdata_hold"}, s_rdata, exp_data);
        end
        s_rready = 1'b1;
        @(posedge clk); #1;
        s_rready = 1'b0;
        checkOutput({tag, "_rvalid_clear"}, 64'(s_rvalid), 64'd0);
    endtask

    initial begin
        int          upd_before;
        logic [31:0] addr;
        int          kind;
        int          idx;

        rst = 1'b1;
        s_awaddr = '0; s_awvalid = 0; s_wdata = '0; s_wstrb = '0; s_wvalid = 0;
        s_bready = 0; s_araddr = '0; s_arvalid = 0; s_rready = 0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        checkOutput("rst_bvalid", 64'(s_bvalid), 64'd0);
        checkOutput("rst_rvalid", 64'(s_rvalid), 64'd0);
        checkOutput("rst_bresp", 64'(s_bresp), 64'd0);
        checkOutput("rst_rresp", 64'(s_rresp), 64'd0);
        checkOutput("rst_rdata", s_rdata, 64'd0);
        checkOutput("rst_cfg_upd", 64'(cfg_upd), 64'd0);
        checkOutput("rst_regs", 64'(regMismatches()), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("rst_readies", 64'({s_awready, s_wready, s_arready}), 64'h7);

        // Simultaneous AW/W to index 0, then read back
        applyStimulus("idx0", 32'h00, 64'h0000_0000_1000_0000, 8'hFF, 0, 0, 0);
        checkOutput("idx0_value", int_cfg_regs[0], 64'h0000_0000_1000_0000);
        readBack("idx0_rd", 32'h00, 0);

        // All-ones into offset and flags registers
        applyStimulus("idx2", 32'h10, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 0, 0);
        applyStimulus("idx3", 32'h18, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 0, 0);
        checkOutput("idx2_value", int_cfg_regs[2], 64'h0000_00FF_FFFF_FFFF);
        checkOutput("idx3_value", int_cfg_regs[3], 64'h0000_0000_0000_000F);

        // W ahead of AW, then AW ahead of W, with B held off
        applyStimulus("w_first", 32'h28, 64'h0000_0000_DEAD_BEEF, 8'hFF, 3, 0, 5);
        applyStimulus("aw_first", 32'h48, 64'h0000_0000_0BAD_F00D, 8'hFF, 0, 3, 5);

        // Byte strobes on index 1
        applyStimulus("strb_init", 32'h08, 64'h0000_0000_AABB_CCDD, 8'hFF, 0, 0, 0);
        applyStimulus("strb_0f", 32'h08, 64'h0000_0000_1122_3344, 8'h0F, 0, 0, 0);
        checkOutput("strb_0f_value", int_cfg_regs[1], 64'h0000_0000_1122_3344);
        applyStimulus("strb_01", 32'h08, 64'h0000_0000_0000_0099, 8'h01, 0, 0, 0);
        checkOutput("strb_01_value", int_cfg_regs[1], 64'h0000_0000_1122_3399);

        // Out-of-range index
        applyStimulus("oob_wr", 32'h200, 64'h1234_5678_9ABC_DEF0, 8'hFF, 0, 0, 0);
        readBack("oob_rd", 32'h200, 1);

        // Complete write pair and a read present together: write goes first
        upd_before = upd_total;
        s_awvalid = 1'b1; s_awaddr = 32'h30;
        s_wvalid = 1'b1; s_wdata = 64'h0000_0000_CAFE_0001; s_wstrb = 8'hFF;
        @(posedge clk); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        s_arvalid = 1'b1; s_araddr = 32'h30;
        checkOutput("prio_arready_blocked", 64'(s_arready), 64'd0);
        void'(modelWrite(32'h30, 64'h0000_0000_CAFE_0001, 8'hFF));
        @(posedge clk); #1;
        checkOutput("prio_bvalid", 64'(s_bvalid), 64'd1);
        checkOutput("prio_rvalid_none", 64'(s_rvalid), 64'd0);
        checkOutput("prio_committed", 64'(regMismatches()), 64'd0);
        repeat (2) begin
            @(posedge clk); #1;
            checkOutput("prio_arready_wresp", 64'(s_arready), 64'd0);
        end
        s_bready = 1'b1;
        @(posedge clk); #1;
        s_bready = 1'b0;
        checkOutput("prio_bvalid_clear", 64'(s_bvalid), 64'd0);
        checkOutput("prio_arready_free", 64'(s_arready), 64'd1);
        @(posedge clk); #1;
        s_arvalid = 1'b0;
        checkOutput("prio_rvalid", 64'(s_rvalid), 64'd1);
        checkOutput("prio_rdata", s_rdata, 64'h0000_0000_CAFE_0001);
        s_rready = 1'b1;
        @(posedge clk); #1;
        s_rready = 1'b0;
        checkOutput("prio_upd_count", 64'(upd_total - upd_before), 64'd1);

        // Randomized traffic against the model, including out-of-range indices
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 2);
            idx  = $urandom_range(0, N_REGS + 1);
            addr = (32'(idx) << 3) | 32'($urandom_range(0, 7));
            if (kind < 2)
                applyStimulus("rnd_wr", addr, {$urandom, $urandom}, 8'($urandom_range(0, 255)),
                              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            else
                readBack("rnd_rd", addr, $urandom_range(0, 2));
        end

        // Reset while a read response is pending
        s_arvalid = 1'b1; s_araddr = 32'h10;
        @(posedge clk); #1;
        s_arvalid = 1'b0;
        checkOutput("rrst_rvalid_before", 64'(s_rvalid), 64'd1);
        rst = 1'b1;
        #1;
        checkOutput("rrst_rvalid_drop", 64'(s_rvalid), 64'd0);
        modelReset();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("rrst_regs", 64'(regMismatches()), 64'd0);
        checkOutput("rrst_idle", 64'({s_awready, s_wready, s_arready, s_bvalid, s_rvalid}), 64'h1C);
        readBack("rrst_rd", 32'h10, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
